// File: rtl/pattern_line_gen.sv
// pattern_line_gen: test-pattern line generator.
// On a rising edge of line_req while idle, the generator captures the line
// index, the pattern mode and the solid colour. It then writes H_ACTIVE
// consecutive pixels into the line-buffer write port, one per clock, and
// reports completion with a line_done pulse. Rising edges that arrive while a
// line is in progress are dropped and flagged with an overrun pulse.
module pattern_line_gen #(
    parameter int                  H_ACTIVE  = 800,
    parameter int                  V_ACTIVE  = 480,
    parameter int                  ADDR_W    = 10,
    parameter int                  LINE_W    = 10,
    parameter int                  CH_W      = 8,
    parameter int                  CELL_LOG2 = 4,
    parameter logic [3*CH_W-1:0]   FG        = 24'hFFFFFF,
    parameter logic [3*CH_W-1:0]   BG        = 24'h888888
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             mode,
    input  logic [3*CH_W-1:0]      solid_color,
    input  logic                   line_req,
    input  logic [LINE_W-1:0]      line_idx,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [3*CH_W-1:0]      wr_data,
    output logic                   wr_en,
    output logic                   busy,
    output logic                   line_done,
    output logic                   overrun
);

    localparam int DATA_W = 3 * CH_W;

    // Last pixel of the line, last pixel inside one colour bar, last line of
    // the frame. All are compared against registered counters, so no divider
    // or multiplier appears in the datapath.
    localparam logic [ADDR_W-1:0] X_LAST   = ADDR_W'(H_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] BAR_LAST = ADDR_W'(H_ACTIVE / 8 - 1);
    localparam logic [LINE_W-1:0] Y_LAST   = LINE_W'(V_ACTIVE - 1);

    // Pattern mode encodings. Codes 5..7 produce black.
    localparam logic [2:0] MODE_CHECKER = 3'd0;
    localparam logic [2:0] MODE_BARS    = 3'd1;
    localparam logic [2:0] MODE_RAMP    = 3'd2;
    localparam logic [2:0] MODE_SOLID   = 3'd3;
    localparam logic [2:0] MODE_BORDER  = 3'd4;

    // Request protocol: there is no ready signal. line_req is a level, and a
    // request is its rising edge as seen against req_q. A rising edge seen in
    // IDLE is accepted on that same clock edge. A rising edge seen in RUN or
    // DONE is dropped and reported through overrun. req_q resets to 1, so a
    // line_req that is already high when reset releases is not a request.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FSM state. It is kept as a named signal so checkers can bind to it.
    state_t              state;

    logic                req_q;
    logic                req_rise;

    // Values captured when a line is accepted. They stay fixed for the line.
    logic [ADDR_W-1:0]   x;
    logic [LINE_W-1:0]   y;
    logic [2:0]          mode_q;
    logic [DATA_W-1:0]   solid_q;

    // Colour-bar tracking: position inside the current bar and the bar number.
    logic [ADDR_W-1:0]   bar_cnt;
    logic [2:0]          bar_idx;

    // Combinational pixel value for the current beat.
    logic [DATA_W-1:0]   pix;
    logic [2:0]          bar_rgb;
    logic [CH_W-1:0]     ramp_val;
    logic                checker_bit;
    logic                on_border;

    assign req_rise = line_req & ~req_q;

    // Map the bar number to on/off flags for R, G and B.
    // The order runs white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    // Pixel function of the captured x, y, mode and solid colour.
    always_comb begin
        pix         = '0;
        ramp_val    = CH_W'(x);
        checker_bit = x[CELL_LOG2] ^ y[CELL_LOG2];
        on_border   = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
        case (mode_q)
            MODE_CHECKER: pix = checker_bit ? FG : BG;
            MODE_BARS:    pix = {{CH_W{bar_rgb[2]}}, {CH_W{bar_rgb[1]}}, {CH_W{bar_rgb[0]}}};
            MODE_RAMP:    pix = {ramp_val, ramp_val, ramp_val};
            MODE_SOLID:   pix = solid_q;
            MODE_BORDER:  pix = on_border ? FG : BG;
            default:      pix = '0;
        endcase
    end

    // Line FSM. The write port and the status pulses are registered here, so
    // wr_addr and wr_data always describe the same beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= 1'b1;
            x         <= '0;
            y         <= '0;
            mode_q    <= '0;
            solid_q   <= '0;
            bar_cnt   <= '0;
            bar_idx   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            line_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            req_q     <= line_req;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            line_done <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    // wr_addr and wr_data keep their last values while idle.
                    if (req_rise) begin
                        state   <= RUN;
                        x       <= '0;
                        y       <= line_idx;
                        mode_q  <= mode;
                        solid_q <= solid_color;
                        bar_cnt <= '0;
                        bar_idx <= '0;
                    end
                end
                RUN: begin
                    wr_en   <= 1'b1;
                    busy    <= 1'b1;
                    wr_addr <= x;
                    wr_data <= pix;
                    x       <= x + ADDR_W'(1);
                    if (bar_cnt == BAR_LAST) begin
                        bar_cnt <= '0;
                        bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt + ADDR_W'(1);
                    end
                    if (x == X_LAST) begin
                        state <= DONE;
                    end
                    if (req_rise) begin
                        overrun <= 1'b1;
                    end
                end
                DONE: begin
                    line_done <= 1'b1;
                    state     <= IDLE;
                    if (req_rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_line_gen.sv
// Self-checking bench for pattern_line_gen with the default parameters.
// A table of {mode, line, solid, addr, expected pixel} records drives most
// checks. Hand-written sequences cover overrun, border lines and mid-line reset.
module tb_pattern_line_gen;

    localparam int H = 800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [23:0] solid_color = 24'h0;
    logic        line_req = 1'b0;
    logic [9:0]  line_idx = 10'd0;
    logic [9:0]  wr_addr;
    logic [23:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        line_done;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    pattern_line_gen dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .solid_color (solid_color),
        .line_req    (line_req),
        .line_idx    (line_idx),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .busy        (busy),
        .line_done   (line_done),
        .overrun     (overrun)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Write monitor: samples on the falling edge and records everything it sees.
    logic [23:0] cap [0:1023];
    int          wr_cnt   = 0;
    int          seq_err  = 0;
    int          done_cnt = 0;
    int          done_bad = 0;
    int          ovr_cnt  = 0;
    int          busy_err = 0;
    logic        prev_en  = 1'b0;
    logic [9:0]  prev_addr = 10'd0;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt       <= wr_cnt + 1;
            cap[wr_addr] <= wr_data;
            if (int'(wr_addr) != (prev_en ? int'(prev_addr) + 1 : 0))
                seq_err <= seq_err + 1;
        end
        if (line_done) begin
            done_cnt <= done_cnt + 1;
            if (!prev_en || prev_addr != 10'(H - 1) || wr_en)
                done_bad <= done_bad + 1;
        end
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (busy != wr_en) busy_err <= busy_err + 1;
        prev_en   <= wr_en;
        prev_addr <= wr_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request one line, scramble the inputs right after acceptance, and wait
    // (bounded) for line_done. Then check the write count and line framing.
    task automatic run_line(input logic [2:0] m, input logic [9:0] y, input logic [23:0] s);
        int w0, d0, sq0, db0, o0, b0;
        w0 = wr_cnt; d0 = done_cnt; sq0 = seq_err; db0 = done_bad; o0 = ovr_cnt; b0 = busy_err;
        mode = m; line_idx = y; solid_color = s; line_req = 1'b1;
        @(posedge clk); #1;
        mode = 3'($urandom_range(0, 7));
        line_idx = 10'($urandom_range(0, 1023));
        solid_color = 24'($urandom);
        line_req = 1'b0;
        for (int c = 0; c < 2000 && done_cnt == d0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check($sformatf("writes m%0d y%0d", m, y), 32'(wr_cnt - w0), 32'(H));
        check($sformatf("line_done m%0d y%0d", m, y), 32'(done_cnt - d0), 32'd1);
        check($sformatf("addr_seq m%0d y%0d", m, y), 32'(seq_err - sq0), 32'd0);
        check($sformatf("done_timing m%0d y%0d", m, y), 32'(done_bad - db0), 32'd0);
        check($sformatf("no_overrun m%0d y%0d", m, y), 32'(ovr_cnt - o0), 32'd0);
        check($sformatf("busy m%0d y%0d", m, y), 32'(busy_err - b0), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [9:0]  y;
        logic [23:0] solid;
        int          addr;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] m, input logic [9:0] y,
                                input logic [23:0] s, input int a, input logic [23:0] e);
        vec_t v;
        v.mode = m; v.y = y; v.solid = s; v.addr = a; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Hard time limit so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, d0, o0, errs;

        // Checker, line 16: the first 16-pixel cell is FG, the next is BG.
        add(3'd0, 10'd16, 24'h0, 0,   24'hFFFFFF);
        add(3'd0, 10'd16, 24'h0, 15,  24'hFFFFFF);
        add(3'd0, 10'd16, 24'h0, 16,  24'h888888);
        add(3'd0, 10'd16, 24'h0, 31,  24'h888888);
        add(3'd0, 10'd16, 24'h0, 32,  24'hFFFFFF);
        add(3'd0, 10'd16, 24'h0, 799, 24'h888888);
        // Checker, line 0: the phase is inverted.
        add(3'd0, 10'd0,  24'h0, 0,   24'h888888);
        add(3'd0, 10'd0,  24'h0, 16,  24'hFFFFFF);
        // Colour bars, each 100 pixels wide.
        add(3'd1, 10'd7,  24'h0, 99,  24'hFFFFFF);
        add(3'd1, 10'd7,  24'h0, 100, 24'hFFFF00);
        add(3'd1, 10'd7,  24'h0, 200, 24'h00FFFF);
        add(3'd1, 10'd7,  24'h0, 300, 24'h00FF00);
        add(3'd1, 10'd7,  24'h0, 400, 24'hFF00FF);
        add(3'd1, 10'd7,  24'h0, 500, 24'hFF0000);
        add(3'd1, 10'd7,  24'h0, 699, 24'h0000FF);
        add(3'd1, 10'd7,  24'h0, 700, 24'h000000);
        add(3'd1, 10'd7,  24'h0, 799, 24'h000000);
        // Grey ramp, wrapping every 256 pixels.
        add(3'd2, 10'd3,  24'h0, 0,   24'h000000);
        add(3'd2, 10'd3,  24'h0, 255, 24'hFFFFFF);
        add(3'd2, 10'd3,  24'h0, 256, 24'h000000);
        add(3'd2, 10'd3,  24'h0, 300, 24'h2C2C2C);
        // Solid colour.
        add(3'd3, 10'd9,  24'h123456, 0,   24'h123456);
        add(3'd3, 10'd9,  24'h123456, 799, 24'h123456);
        // Border on an interior line and on the last line of the frame.
        add(3'd4, 10'd5,  24'h0, 0,   24'hFFFFFF);
        add(3'd4, 10'd5,  24'h0, 1,   24'h888888);
        add(3'd4, 10'd5,  24'h0, 798, 24'h888888);
        add(3'd4, 10'd5,  24'h0, 799, 24'hFFFFFF);
        add(3'd4, 10'd479, 24'h0, 400, 24'hFFFFFF);
        // Undefined modes produce black.
        add(3'd5, 10'd2,  24'hABCDEF, 10, 24'h000000);
        add(3'd7, 10'd2,  24'hABCDEF, 10, 24'h000000);

        // Reset block.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset wr_en", 32'(wr_en), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset line_done", 32'(line_done), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset wr_data", 32'(wr_data), 32'd0);

        // Table-driven pixel checks. A new line is generated whenever the key changes.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].y != vecs[i-1].y ||
                vecs[i].solid != vecs[i-1].solid)
                run_line(vecs[i].mode, vecs[i].y, vecs[i].solid);
            check($sformatf("pix m%0d y%0d a%0d", vecs[i].mode, vecs[i].y, vecs[i].addr),
                  32'(cap[vecs[i].addr]), 32'(vecs[i].exp));
        end

        // Border, line 0: every pixel is FG.
        run_line(3'd4, 10'd0, 24'h0);
        errs = 0;
        for (int a = 0; a < H; a++) if (cap[a] !== 24'hFFFFFF) errs++;
        check("border line0 all FG", 32'(errs), 32'd0);

        // Border, line 5: only the two end pixels are FG.
        run_line(3'd4, 10'd5, 24'h0);
        errs = 0;
        for (int a = 1; a < H - 1; a++) if (cap[a] !== 24'h888888) errs++;
        check("border line5 interior BG", 32'(errs), 32'd0);

        // Overrun: a second rising edge 10 cycles into a checker line,
        // with the mode switched to solid at the same time.
        for (int a = 0; a < H; a++) cap[a] = 24'h0;
        w0 = wr_cnt; d0 = done_cnt; o0 = ovr_cnt;
        mode = 3'd0; line_idx = 10'd16; line_req = 1'b1;
        @(posedge clk); #1;
        line_req = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        line_req = 1'b1; mode = 3'd3; solid_color = 24'h123456;
        for (int c = 0; c < 2000 && done_cnt == d0; c++) @(posedge clk);
        #1 line_req = 1'b0;
        repeat (900) @(posedge clk);
        #1;
        check("overrun pulses", 32'(ovr_cnt - o0), 32'd1);
        check("overrun writes", 32'(wr_cnt - w0), 32'(H));
        check("overrun line_done", 32'(done_cnt - d0), 32'd1);
        check("overrun pix a0", 32'(cap[0]), 32'hFFFFFF);
        check("overrun pix a16", 32'(cap[16]), 32'h888888);
        check("overrun pix a799", 32'(cap[799]), 32'h888888);

        // Reset in the middle of a line, with line_req held high through release.
        d0 = done_cnt;
        mode = 3'd0; line_idx = 10'd16; line_req = 1'b1;
        for (int c = 0; c < 2000 && !(wr_en && wr_addr == 10'd400); c++) begin
            @(posedge clk); #1;
        end
        check("reached write 400", 32'(wr_en && wr_addr == 10'd400), 32'd1);
        rst = 1'b1;
        #1;
        check("async reset wr_en", 32'(wr_en), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset wr_addr", 32'(wr_addr), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        w0 = wr_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("held req no writes", 32'(wr_cnt - w0), 32'd0);
        check("aborted no line_done", 32'(done_cnt - d0), 32'd0);
        check("after reset busy", 32'(busy), 32'd0);
        line_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_line(3'd0, 10'd16, 24'h0);
        check("post reset pix a16", 32'(cap[16]), 32'h888888);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
